// File: rtl/uncached_memory_port.sv
// Cacheless responder: serves cpu_to_l1 loads/stores over the 64-bit l1_to_mem dword port.
// Define UNCACHED_MEMORY_PORT_MISALIGN_CHECK_EN to flag misaligned accesses instead of aligning down.
module uncached_memory_port #(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_to_l1__valid,
  output logic        cpu_to_l1__ready,
  input  logic        cpu_to_l1__we,
  input  logic [63:0] cpu_to_l1__addr,
  input  logic [63:0] cpu_to_l1__wr_data,
  input  logic [2:0]  cpu_to_l1__dtype,
  output logic [63:0] cpu_to_l1__rd_data,
  output logic        cpu_to_l1__err,
  output logic [60:0] l1_to_mem__addr,
  output logic [63:0] l1_to_mem__wr_data,
  input  logic [63:0] l1_to_mem__rd_data,
  output logic        l1_to_mem__en,
  output logic        l1_to_mem__we
);

`ifdef UNCACHED_MEMORY_PORT_MISALIGN_CHECK_EN
  localparam bit MisalignCheck = 1'b1;
`else
  localparam bit MisalignCheck = 1'b0;
`endif

  typedef enum logic [2:0] {StIdle, StRd, StRdWait, StCap, StWr} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [63:0] addr_q, wr_data_q, mem_wdata_q, rd_data_q;
  logic [2:0]  dtype_q;
  logic        we_q, err_q;

  // Right-justified byte mask of an access type.
  function automatic logic [7:0] size_mask(input logic [2:0] dtype);
    case (dtype)
      3'd1, 3'd4: size_mask = 8'h0f;
      3'd2, 3'd5: size_mask = 8'h03;
      3'd3, 3'd6: size_mask = 8'h01;
      default:    size_mask = 8'hff;
    endcase
  endfunction

  logic [7:0]  req_mask;
  logic [2:0]  req_align;
  logic        req_is_d, req_misaligned;
  logic [63:0] req_addr;

  always_comb begin
    req_mask       = size_mask(cpu_to_l1__dtype);
    // Size minus one, i.e. the address bits that must be zero.
    req_align      = {req_mask[7], req_mask[3], req_mask[1]};
    req_is_d       = req_mask[7];
    req_misaligned = |(cpu_to_l1__addr[2:0] & req_align);
    req_addr       = cpu_to_l1__addr;
    if (!MisalignCheck) req_addr[2:0] = cpu_to_l1__addr[2:0] & ~req_align;
  end

  logic [5:0]  shamt;
  logic [7:0]  cur_mask;
  logic [63:0] bit_mask, lane_mask, rd_shifted, merged, load_val;

  always_comb begin
    shamt      = {addr_q[2:0], 3'b000};
    cur_mask   = size_mask(dtype_q);
    bit_mask   = '0;
    for (int i = 0; i < 8; i++) bit_mask[8*i +: 8] = {8{cur_mask[i]}};
    lane_mask  = bit_mask << shamt;
    merged     = (l1_to_mem__rd_data & ~lane_mask) | ((wr_data_q << shamt) & lane_mask);
    rd_shifted = l1_to_mem__rd_data >> shamt;
    case (dtype_q)
      3'd1:    load_val = {{32{rd_shifted[31]}}, rd_shifted[31:0]};
      3'd2:    load_val = {{48{rd_shifted[15]}}, rd_shifted[15:0]};
      3'd3:    load_val = {{56{rd_shifted[7]}},  rd_shifted[7:0]};
      3'd4:    load_val = {32'b0, rd_shifted[31:0]};
      3'd5:    load_val = {48'b0, rd_shifted[15:0]};
      3'd6:    load_val = {56'b0, rd_shifted[7:0]};
      default: load_val = rd_shifted;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (cpu_to_l1__valid) begin
          if (MisalignCheck && req_misaligned) state_d = StIdle;
          else if (cpu_to_l1__we && req_is_d)  state_d = StWr;
          else                                 state_d = StRd;
        end
      end
      StRd: begin
        cnt_d   = 3'(RD_LATENCY - 1);
        state_d = (RD_LATENCY == 1) ? StCap : StRdWait;
      end
      StRdWait: begin
        if (cnt_q == 3'd1) state_d = StCap;
        else               cnt_d   = cnt_q - 3'd1;
      end
      StCap:   state_d = we_q ? StWr : StIdle;
      StWr:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_q      <= '0;
      wr_data_q   <= '0;
      dtype_q     <= '0;
      we_q        <= 1'b0;
      mem_wdata_q <= '0;
      rd_data_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == StIdle && cpu_to_l1__valid) begin
        addr_q    <= req_addr;
        we_q      <= cpu_to_l1__we;
        wr_data_q <= cpu_to_l1__wr_data;
        dtype_q   <= cpu_to_l1__dtype;
        if (MisalignCheck && req_misaligned)  err_q       <= 1'b1;
        else if (cpu_to_l1__we && req_is_d)   mem_wdata_q <= cpu_to_l1__wr_data;
      end
      if (state_q == StCap) begin
        if (we_q) begin
          mem_wdata_q <= merged;
        end else begin
          rd_data_q <= load_val;
          err_q     <= 1'b0;
        end
      end
      if (state_q == StWr) err_q <= 1'b0;
    end
  end

  assign cpu_to_l1__ready   = (state_q == StIdle);
  assign cpu_to_l1__rd_data = rd_data_q;
  assign cpu_to_l1__err     = err_q;
  assign l1_to_mem__addr    = addr_q[63:3];
  assign l1_to_mem__wr_data = mem_wdata_q;
  assign l1_to_mem__en      = (state_q == StRd) || (state_q == StWr);
  assign l1_to_mem__we      = (state_q == StWr);

endmodule

// File: doc/uncached_memory_port.md
# uncached_memory_port

Cacheless responder for the CPU's `cpu_to_l1` load/store/fetch interface, driving the 64-bit `l1_to_mem` dword memory port. It performs sub-dword alignment, load sign/zero extension, read-modify-write for sub-dword stores, and optional misalignment detection. It drops in where the L1 sits, for bring-up and cache-bypass configurations.

## Interface
- `RD_LATENCY`, default 1: memory read latency in cycles, from `en` to valid `l1_to_mem__rd_data`. Legal range is 1–4.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `cpu_to_l1__valid` in 1: request present.
- `cpu_to_l1__ready` out 1: high only in IDLE; request accepted when valid && ready.
- `cpu_to_l1__we` in 1: 1 = store.
- `cpu_to_l1__addr` in 64: byte address.
- `cpu_to_l1__wr_data` in 64: store data, right-justified.
- `cpu_to_l1__dtype` in 3: access type.
  - 0 = D.
  - 1 = W signed.
  - 2 = H signed.
  - 3 = B signed.
  - 4 = W unsigned.
  - 5 = H unsigned.
  - 6 = B unsigned.
  - 7 = treated as D.
- `cpu_to_l1__rd_data` out 64: load result, registered; stable until the next load or error completes.
- `cpu_to_l1__err` out 1: registered; misaligned flag for the last completed request.
- `l1_to_mem__addr` out 61: dword address, equal to `addr[63:3]`.
- `l1_to_mem__wr_data` out 64: dword write data.
- `l1_to_mem__rd_data` in 64: dword read data.
- `l1_to_mem__en` out 1: memory access strobe, one cycle per access.
- `l1_to_mem__we` out 1: write qualifier, valid with `en`.

## Operation
- **States:** IDLE, RD, RD_WAIT, CAP, WR.
- **IDLE:**
  - `ready=1`.
  - On valid, latch addr, we, wr_data and dtype, then branch:
    - D store → WR.
    - Misaligned, when the check is enabled → stays IDLE and sets `err=1`.
    - Otherwise → RD.
- **RD:**
  - `en=1`, `we=0`.
  - Loads counter with `RD_LATENCY-1`.
  - Goes to CAP if `RD_LATENCY==1`, else to RD_WAIT.
- **RD_WAIT:** counter decrements; goes to CAP when it reaches 1.
- **CAP (sample `rd_data`):**
  - Load: byte lane = `addr[2:0]`. Extract the size field at lane*8, sign- or zero-extend to 64, write `cpu_to_l1__rd_data`, `err=0`, then IDLE.
  - Store: merge `wr_data` shifted by lane*8 under the byte mask (B 1, H 2, W 4 bytes), then WR.
- **WR:**
  - `en=1`, `we=1`, `l1_to_mem__wr_data` = merged dword, or the raw wr_data for D.
  - Sets `err=0`, then IDLE.
- **`ready` derivation:** combinational from registered state. It falls the cycle after acceptance, so a waiting requester sees low until completion.
- **Memory outputs:** `en` and `we` are 0 in every state other than RD and WR.
- **Reset values:**
  - state = IDLE, so `ready=1`.
  - `rd_data=0`, `err=0`.
  - `en=0`, `we=0`.
  - `l1_to_mem__addr=0`, `l1_to_mem__wr_data=0`.
- **Reset mid-operation:** abandons the request with no WR issued. The next cycle is IDLE with `ready=1`.
- **Valid while not IDLE:** ignored; the requester holds it.

## Timing
Acceptance happens at cycle 0. L = `RD_LATENCY`.
- Load: RD at cycle 1, CAP at 1+L, `ready` and valid `rd_data` at 2+L (cycle 3 for L=1).
- Sub-dword store: WR at 2+L, `ready` at 3+L.
- D store: WR at cycle 1, `ready` at cycle 2.
- Misaligned (macro on): `err=1`, `ready` stays 1 at cycle 1, no memory access.
- Back-to-back: a new request can be accepted in the first IDLE cycle after completion.

## Configuration
- `UNCACHED_MEMORY_PORT_MISALIGN_CHECK_EN` defined:
  - `addr` not a multiple of the access size sets `err=1` and produces no memory access.
  - `rd_data` is left unchanged.
- Macro undefined:
  - Address bits below the access size are forced to 0, so the access is aligned down.
  - `err` is tied to 0.

## Test plan
- **Signed byte load:** memory[0x200] = 0x0000_0000_8000_0000; LB (dtype 3) at 0x1003 → `addr=0x200`, `rd_data=0xFFFF_FFFF_FFFF_FF80`, `ready` back at cycle 3 (L=1). With LBU (dtype 6) → 0x80.
- **Half store RMW:** memory[0x400] = 0x1122334455667788; SH (dtype 2) of 0xBEEF at 0x2006 → one read then one write of 0xBEEF334455667788 with `we=1`, `ready` at cycle 4.
- **D store, no read:** SD 0xDEADBEEFCAFEF00D at 0x10 → only `en`+`we` at cycle 1 (`addr=0x2`), no read strobe, `ready` at cycle 2.
- **Misaligned word:** LW (dtype 1) at 0x1002 with macro on → `err=1`, no `en`, previous `rd_data` retained. Without the macro → reads the word at 0x1000, `err=0`.
- **Latency:** `RD_LATENCY=3` LWU (dtype 4) at 0x4 with memory dword 0xF000_0001_0000_0002 → `rd_data=0x0000_0000_F000_0001`, `ready` back at cycle 5.
- **Reset mid-store:** `rst` asserted in the CAP cycle of a byte store → no `we` ever asserted, next cycle `ready=1`, `rd_data=0`, `err=0`.
